// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt responder and its controller-side peers.
package irq_pkg;

    localparam int unsigned MS_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DISPATCH,
        ST_WAIT_DONE,
        ST_ACK,
        ST_HOLDOFF
    } state_t;

    function automatic int unsigned irq_id_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/irq_responder_if.sv
// Valid/ready + done handshake between the responder and the service FSM.
interface irq_responder_if #(
    parameter int unsigned ID_W = 1
);
    logic            svc_valid;
    logic [ID_W-1:0] svc_id;
    logic            svc_ready;
    logic            svc_done;

    modport master (output svc_valid, output svc_id, input svc_ready, input svc_done);
    modport slave  (input svc_valid, input svc_id, output svc_ready, output svc_done);
endinterface

// File: rtl/ms_holdoff_timer.sv
// Millisecond countdown: load a ms value, pulse expired on the last cycle of ms*CLK_PER_MS.
module ms_holdoff_timer
    import irq_pkg::*;
#(
    parameter int unsigned CLK_PER_MS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [MS_W-1:0] ms,
    output logic            expired
);
    localparam int unsigned SUB_W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(CLK_PER_MS - 1);

    logic [MS_W-1:0]  ms_cnt;
    logic [SUB_W-1:0] sub_cnt;

    assign expired = (ms_cnt == MS_W'(1)) && (sub_cnt == '0);

    // Final millisecond does not reload sub_cnt so both counters rest at 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            ms_cnt  <= '0;
            sub_cnt <= '0;
        end else if (load) begin
            ms_cnt  <= ms;
            sub_cnt <= (ms == '0) ? '0 : SUB_MAX;
        end else if (ms_cnt != '0) begin
            if (sub_cnt == '0) begin
                ms_cnt <= ms_cnt - MS_W'(1);
                if (ms_cnt != MS_W'(1)) begin
                    sub_cnt <= SUB_MAX;
                end
            end else begin
                sub_cnt <= sub_cnt - SUB_W'(1);
            end
        end
    end

endmodule

// File: rtl/irq_responder.sv
// Latches interrupt edges, dispatches the lowest pending index to the service FSM,
// acks the controller after done, then waits out a programmable holdoff.
module irq_responder
    import irq_pkg::*;
#(
    parameter int unsigned N_IRQ      = 2,
    parameter int unsigned CLK_PER_MS = 1
) (
    input  logic             mclk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq,
    input  logic [MS_W-1:0]  holdoff_ms,
    irq_responder_if.master  svc,
    output logic [N_IRQ-1:0] irq_ack,
    output logic             busy,
    output logic [N_IRQ-1:0] overrun
);
    localparam int unsigned ID_W = irq_id_w(N_IRQ);

    state_t           state;
    logic [N_IRQ-1:0] irq_q;
    logic [N_IRQ-1:0] pending;
    logic [N_IRQ-1:0] rise;
    logic [N_IRQ-1:0] clr;
    logic [N_IRQ-1:0] id_onehot;
    logic [ID_W-1:0]  sel;
    logic             any_pending;
    logic             expired;

    assign rise      = irq & ~irq_q;
    assign id_onehot = N_IRQ'(1) << svc.svc_id;
    assign clr       = (state == ST_DISPATCH && svc.svc_valid && svc.svc_ready) ? id_onehot : '0;
    assign busy      = (state != ST_IDLE);

    always_comb begin
        sel         = '0;
        any_pending = 1'b0;
        for (int unsigned i = 0; i < N_IRQ; i++) begin
            if (pending[i] && !any_pending) begin
                sel         = ID_W'(i);
                any_pending = 1'b1;
            end
        end
    end

    // A rise on the clearing cycle re-arms the source without flagging overrun.
    always_ff @(posedge mclk) begin
        if (rst) begin
            irq_q   <= '0;
            pending <= '0;
            overrun <= '0;
        end else begin
            irq_q   <= irq;
            pending <= (pending & ~clr) | rise;
            overrun <= overrun | (rise & pending & ~clr);
        end
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            state         <= ST_IDLE;
            svc.svc_valid <= 1'b0;
            svc.svc_id    <= '0;
            irq_ack       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_pending) begin
                        svc.svc_id    <= sel;
                        svc.svc_valid <= 1'b1;
                        state         <= ST_DISPATCH;
                    end
                end
                ST_DISPATCH: begin
                    if (svc.svc_valid && svc.svc_ready) begin
                        svc.svc_valid <= 1'b0;
                        state         <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (svc.svc_done) begin
                        irq_ack <= id_onehot;
                        state   <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    irq_ack <= '0;
                    state   <= (holdoff_ms == '0) ? ST_IDLE : ST_HOLDOFF;
                end
                ST_HOLDOFF: begin
                    if (expired) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    ms_holdoff_timer #(
        .CLK_PER_MS(CLK_PER_MS)
    ) u_holdoff (
        .clk    (mclk),
        .rst    (rst),
        .load   (state == ST_ACK),
        .ms     (holdoff_ms),
        .expired(expired)
    );

endmodule

// File: tb/tb_irq_responder.sv
// Directed bench for irq_responder with a cycle-level behavioural model and literal spot checks.
module tb_irq_responder;

    logic        mclk = 1'b0;
    logic        rst;
    logic [1:0]  irq;
    logic [15:0] holdoff_ms;
    logic [1:0]  irq_ack;
    logic        busy;
    logic [1:0]  overrun;

    irq_responder_if #(.ID_W(1)) svc_bus ();

    irq_responder #(
        .N_IRQ     (2),
        .CLK_PER_MS(3)
    ) dut (
        .mclk      (mclk),
        .rst       (rst),
        .irq       (irq),
        .holdoff_ms(holdoff_ms),
        .svc       (svc_bus),
        .irq_ack   (irq_ack),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 mclk = ~mclk;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pending/overrun sets, one job at a time, holdoff as a flat cycle count.
    logic [1:0] m_pend, m_ovr, m_ack, m_prev, m_rise, m_clr;
    logic       m_valid, m_busy, m_wait, m_id;
    int         m_hold;

    always @(posedge mclk) begin
        if (rst) begin
            m_pend = '0; m_ovr = '0; m_ack = '0; m_prev = '0;
            m_valid = 1'b0; m_busy = 1'b0; m_wait = 1'b0; m_id = 1'b0; m_hold = 0;
        end else begin
            m_rise = irq & ~m_prev;
            m_prev = irq;
            m_clr  = '0;
            if (!m_busy) begin
                if (m_pend != 2'b00) begin
                    m_id = m_pend[0] ? 1'b0 : 1'b1;
                    m_valid = 1'b1;
                    m_busy = 1'b1;
                end
            end else if (m_valid) begin
                if (svc_bus.svc_ready) begin
                    m_clr[m_id] = 1'b1;
                    m_valid = 1'b0;
                    m_wait = 1'b1;
                end
            end else if (m_wait) begin
                if (svc_bus.svc_done) begin
                    m_ack = '0;
                    m_ack[m_id] = 1'b1;
                    m_wait = 1'b0;
                end
            end else if (m_ack != 2'b00) begin
                m_ack = '0;
                m_hold = int'(holdoff_ms) * 3;
                if (m_hold == 0) m_busy = 1'b0;
            end else begin
                m_hold--;
                if (m_hold <= 0) m_busy = 1'b0;
            end
            m_ovr  = m_ovr | (m_rise & m_pend & ~m_clr);
            m_pend = (m_pend & ~m_clr) | m_rise;
        end
    end

    always @(negedge mclk) begin
        if (mon_en) begin
            check("mdl_svc_valid", svc_bus.svc_valid, m_valid);
            if (m_valid) check("mdl_svc_id", svc_bus.svc_id, m_id);
            check("mdl_irq_ack", irq_ack, m_ack);
            check("mdl_busy", busy, m_busy);
            check("mdl_overrun", overrun, m_ovr);
        end
    end

    task automatic adv(input int n);
        repeat (n) begin
            @(posedge mclk);
            #2;
        end
    endtask

    task automatic serve(input logic exp_id);
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < 100) begin
            @(negedge mclk);
            if (svc_bus.svc_valid === 1'b1) seen = 1'b1;
            n++;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL serve_timeout: svc_valid never rose, expected id %0d", exp_id);
            return;
        end
        check("serve_id", svc_bus.svc_id, exp_id);
        adv(1); svc_bus.svc_ready = 1'b1;
        adv(1); svc_bus.svc_ready = 1'b0;
        adv(1); svc_bus.svc_done = 1'b1;
        adv(1); svc_bus.svc_done = 1'b0;
        @(negedge mclk);
        check("serve_ack", irq_ack, 2'b01 << exp_id);
        adv(1);
        @(negedge mclk);
        check("serve_ack_clear", irq_ack, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; irq = 2'b00; holdoff_ms = 16'd0;
        svc_bus.svc_ready = 1'b0; svc_bus.svc_done = 1'b0;
        adv(1);
        mon_en = 1'b1;
        adv(2);
        rst = 1'b0;
        @(negedge mclk);
        check("rst_busy", busy, 1'b0);
        check("rst_valid", svc_bus.svc_valid, 1'b0);
        check("rst_ack", irq_ack, 2'b00);
        check("rst_overrun", overrun, 2'b00);

        // Basic latency: rise at t=0, valid at t=2, done at t=5, ack at t=6, idle at t=7.
        adv(1); irq = 2'b01; svc_bus.svc_ready = 1'b1;
        adv(1); @(negedge mclk);
        check("t2_valid_c1", svc_bus.svc_valid, 1'b0);
        check("t2_busy_c1", busy, 1'b0);
        adv(1); @(negedge mclk);
        check("t2_valid_c2", svc_bus.svc_valid, 1'b1);
        check("t2_id_c2", svc_bus.svc_id, 1'b0);
        check("t2_busy_c2", busy, 1'b1);
        adv(1); @(negedge mclk);
        check("t2_valid_c3", svc_bus.svc_valid, 1'b0);
        adv(2); svc_bus.svc_done = 1'b1;
        adv(1); svc_bus.svc_done = 1'b0; svc_bus.svc_ready = 1'b0;
        @(negedge mclk);
        check("t2_ack_c6", irq_ack, 2'b01);
        adv(1); @(negedge mclk);
        check("t2_ack_c7", irq_ack, 2'b00);
        check("t2_busy_c7", busy, 1'b0);

        // Simultaneous edges: index 0 first, then index 1.
        irq = 2'b00; adv(1); irq = 2'b11;
        serve(1'b0);
        serve(1'b1);
        adv(3);

        // Holdoff 2 ms * 3 clk = 6 cycles; holdoff change mid-holdoff is ignored.
        holdoff_ms = 16'd2; irq = 2'b00;
        adv(1); irq = 2'b01;
        adv(3); irq = 2'b11;
        serve(1'b0);
        holdoff_ms = 16'd9;
        check("t4_busy_h1", busy, 1'b1);
        for (int k = 2; k <= 7; k++) begin
            adv(1); @(negedge mclk);
            check("t4_valid_hold", svc_bus.svc_valid, 1'b0);
            check("t4_busy_hold", busy, (k <= 6) ? 1'b1 : 1'b0);
        end
        adv(1); @(negedge mclk);
        check("t4_valid_after", svc_bus.svc_valid, 1'b1);
        check("t4_id_after", svc_bus.svc_id, 1'b1);
        serve(1'b1);
        holdoff_ms = 16'd0;
        adv(35);
        check("t4_busy_long_hold_done", busy, 1'b0);

        // Overrun on second edge while pending; served once.
        irq = 2'b00; adv(1); irq = 2'b01;
        adv(1); irq = 2'b00;
        adv(1); irq = 2'b01;
        adv(1); @(negedge mclk);
        check("t5_overrun", overrun, 2'b01);
        serve(1'b0);
        for (int k = 0; k < 8; k++) begin
            adv(1); @(negedge mclk);
            check("t5_no_redispatch", svc_bus.svc_valid, 1'b0);
        end

        // Edge on source 1 coincides with its clear: stays pending, no overrun.
        irq = 2'b11;
        adv(2); irq = 2'b01;
        @(negedge mclk);
        check("t5b_valid", svc_bus.svc_valid, 1'b1);
        check("t5b_id", svc_bus.svc_id, 1'b1);
        adv(1); irq = 2'b11; svc_bus.svc_ready = 1'b1;
        adv(1); svc_bus.svc_ready = 1'b0;
        @(negedge mclk);
        check("t5b_overrun", overrun, 2'b01);
        adv(1); svc_bus.svc_done = 1'b1;
        adv(1); svc_bus.svc_done = 1'b0;
        @(negedge mclk);
        check("t5b_ack", irq_ack, 2'b10);
        adv(2); @(negedge mclk);
        check("t5b_redispatch", svc_bus.svc_valid, 1'b1);
        check("t5b_redispatch_id", svc_bus.svc_id, 1'b1);
        serve(1'b1);
        adv(5); @(negedge mclk);
        check("t5b_idle", busy, 1'b0);

        // Ready held low: request stays put; held level does not re-trigger.
        irq = 2'b10; adv(1); irq = 2'b11;
        adv(2);
        for (int k = 0; k < 10; k++) begin
            @(negedge mclk);
            check("t6_valid_stable", svc_bus.svc_valid, 1'b1);
            check("t6_id_stable", svc_bus.svc_id, 1'b0);
            adv(1);
        end
        serve(1'b0);
        for (int k = 0; k < 10; k++) begin
            adv(1); @(negedge mclk);
            check("t6_level_no_dispatch", svc_bus.svc_valid, 1'b0);
            check("t6_level_idle", busy, 1'b0);
        end

        // Reset mid-dispatch discards the request; no ack follows.
        irq = 2'b10; adv(1); irq = 2'b11;
        adv(2); @(negedge mclk);
        check("t1_valid_before", svc_bus.svc_valid, 1'b1);
        adv(1); rst = 1'b1; irq = 2'b00;
        adv(1); rst = 1'b0;
        @(negedge mclk);
        check("t1_valid", svc_bus.svc_valid, 1'b0);
        check("t1_busy", busy, 1'b0);
        check("t1_ack", irq_ack, 2'b00);
        check("t1_overrun", overrun, 2'b00);
        for (int k = 0; k < 5; k++) begin
            adv(1); @(negedge mclk);
            check("t1_no_pending", svc_bus.svc_valid, 1'b0);
            check("t1_no_ack", irq_ack, 2'b00);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
